a51_burst_decipher: RTL and testbench
=====================================

# a51_burst_decipher

A5/1 receive-side engine: takes a 64-bit session key, 22-bit frame number and a 114-bit ciphertext burst, regenerates the matching A5/1 keystream block, and returns the plaintext burst. It complements the transmit-side `cipher` path. By default it uses the second 114-bit keystream block (the opposite link direction). It runs load, mix, skip and generate internally from a single start handshake, so no external tick sequencing is needed.

## Interface
- `DIRECTION`, 1, keystream block used: 0 = first 114 bits after mixing, 1 = second 114 bits
- `MASK1`, 19'h72000, R1 feedback taps (bits 18,17,16,13)
- `MASK2`, 22'h300000, R2 feedback taps (bits 21,20)
- `MASK3`, 23'h700080, R3 feedback taps (bits 22,21,20,7)
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous active-low reset
- `start`  in  1  request a burst; accepted only when `busy`=0
- `key`  in  64  session key, sampled on acceptance
- `frame`  in  22  frame number, sampled on acceptance
- `in`  in  114  ciphertext burst, sampled on acceptance
- `busy`  out  1  engine running
- `done`  out  1  one-cycle pulse; `out` valid
- `out`  out  114  plaintext; `out[i] = in[i] ^ ks[i]`, where `ks[0]` is the first bit of the selected block

## Operation
- Reset (`reset_n`=0 at an edge):
  - state IDLE.
  - R1, R2, R3, counter, `out`, `busy` and `done` all 0.
  - A reset mid-run aborts the run; no `done` is produced.
- Register step:
  - Shift left, shifting in `new_bit0` = parity(R & MASK).
  - Majority clocking: maj = majority(R1[8], R2[10], R3[10]). A register steps only if its clocking bit equals maj.
- Keystream bit, taken after the step: R1[18] ^ R2[21] ^ R3[22].
- IDLE:
  - On `start`=1, latch `key`, `frame` and `in`.
  - Clear R1, R2, R3 and `out`; counter=0; `busy`=1; go to LOAD.
- LOAD, 86 cycles:
  - All three registers step unconditionally (no majority).
  - Then bit0 ^= b, where b = `key[c]` for c=0..63 and `frame[c-64]` for c=64..85.
- MIX, 100 cycles: majority stepping; output discarded.
- SKIP, 114 cycles: majority stepping; output discarded. Present only if `DIRECTION`=1; otherwise MIX goes directly to GEN.
- GEN, 114 cycles: majority stepping; step i writes `out[i]` = `in_latched[i]` ^ ks bit.
  - On the edge that completes step 113: `done`=1, `busy`=0, go to IDLE.
- The counter resets to 0 on every phase change.
- `out` holds its value until the next accepted `start`. Only `out` bits 0..i are meaningful before `done`.

## Timing
- Acceptance edge E0: `busy` rises after E0.
- With `DIRECTION`=1:
  - LOAD on edges E1–E86, MIX on E87–E186, SKIP on E187–E300, GEN on E301–E414.
  - `done` is high for the cycle after E414.
- With `DIRECTION`=0: GEN on E187–E300; `done` follows E300.
- `start` while `busy`=1 is ignored; inputs are not resampled.
- `start`=1 in the same cycle as `done`=1 is accepted, since `busy`=0. A new run begins at that edge and `done` drops.
- `busy` and `done` are never high together.
- `key`, `frame` and `in` may change freely after E0.
- `reset_n`=0 coincident with `start`: reset wins.

## Test plan
- All-zero state: `key`=0, `frame`=0, `in`=114'h2AAA…A (alternating) -> registers stay 0, keystream 0, `out`==`in`; `done` exactly 414 cycles after E0.
- Linearity: `key`=64'h1223456789ABCDEF, `frame`=22'h134:
  - Run with `in`=0, then with `in`=114'h3FFFF…F.
  - Require `out1` ^ `out0` == all-ones.
  - `out0` must match the team golden C model, bit order as above, for both `DIRECTION` values.
- Direction split: same `key`/`frame` with `in`=0 -> `DIRECTION`=0 gives `done` at 300 cycles; its `out` differs from the `DIRECTION`=1 result and matches golden block A.
- Round trip: encipher a random burst with the transmit `cipher` path using the same `key`, `frame` and direction -> `a51_burst_decipher` `out` equals the original plaintext.
- Handshake: pulse `start` at cycle 50 of a run with a different `key` -> ignored; result is unchanged. Back-to-back `start` in the `done` cycle -> second run accepted, with `done` 414 cycles later.
- Reset mid-run: drive `reset_n` low during MIX -> next cycle `busy`=0, `done`=0, `out`=0. A fresh `start` then produces the correct result.

Source files
------------

// File: rtl/a51_burst_decipher.sv
// rtl/a51_burst_decipher.sv - A5/1 receive-side burst decipher: key/frame load, mix, optional skip, keystream XOR
module a51_burst_decipher #(
    parameter bit          DIRECTION = 1'b1,
    parameter logic [18:0] MASK1     = 19'h72000,
    parameter logic [21:0] MASK2     = 22'h300000,
    parameter logic [22:0] MASK3     = 23'h700080
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [63:0]  key,
    input  logic [21:0]  frame,
    input  logic [113:0] in,
    output logic         busy,
    output logic         done,
    output logic [113:0] out
);

    typedef enum logic [2:0] {IDLE, LOAD, MIX, SKIP, GEN} state_t;

    state_t         state;
    state_t         state_next;
    logic [6:0]     count;
    logic           phase_end;
    logic [18:0]    r1, r1_next;
    logic [21:0]    r2, r2_next;
    logic [22:0]    r3, r3_next;
    logic [85:0]    load_vec;
    logic [113:0]   in_latched;
    logic           load_bit;
    logic           fb1, fb2, fb3;
    logic           maj;
    logic           en1, en2, en3;
    logic           ks;

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        phase_end  = 1'b0;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                phase_end = (count == 7'd85);
                if (phase_end) state_next = MIX;
            end
            MIX: begin
                phase_end = (count == 7'd99);
                if (phase_end) state_next = DIRECTION ? SKIP : GEN;
            end
            SKIP: begin
                phase_end = (count == 7'd113);
                if (phase_end) state_next = GEN;
            end
            GEN: begin
                phase_end = (count == 7'd113);
                if (phase_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next register contents: unconditional stepping plus key/frame injection in LOAD,
    // majority clocking everywhere else.
    always_comb begin
        fb1      = ^(r1 & MASK1);
        fb2      = ^(r2 & MASK2);
        fb3      = ^(r3 & MASK3);
        maj      = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        load_bit = load_vec[count];
        en1      = (r1[8] == maj);
        en2      = (r2[10] == maj);
        en3      = (r3[10] == maj);
        r1_next  = r1;
        r2_next  = r2;
        r3_next  = r3;
        if (state == LOAD) begin
            r1_next = {r1[17:0], fb1 ^ load_bit};
            r2_next = {r2[20:0], fb2 ^ load_bit};
            r3_next = {r3[21:0], fb3 ^ load_bit};
        end else begin
            if (en1) r1_next = {r1[17:0], fb1};
            if (en2) r2_next = {r2[20:0], fb2};
            if (en3) r3_next = {r3[21:0], fb3};
        end
        ks = r1_next[18] ^ r2_next[21] ^ r3_next[22];
    end

    // Operands are held only while a run is in flight, so they need no reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            load_vec   <= {frame, key};
            in_latched <= in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            count <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    r1    <= '0;
                    r2    <= '0;
                    r3    <= '0;
                    out   <= '0;
                    count <= '0;
                    busy  <= 1'b1;
                end
            end else begin
                r1    <= r1_next;
                r2    <= r2_next;
                r3    <= r3_next;
                count <= phase_end ? 7'd0 : count + 7'd1;
                if (state == GEN) begin
                    out[count] <= in_latched[count] ^ ks;
                    if (phase_end) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_a51_burst_decipher.sv
// tb/tb_a51_burst_decipher.sv - directed/random bench for a51_burst_decipher against a bit-list A5/1 model
module tb_a51_burst_decipher;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start1 = 1'b0;
    logic         start0 = 1'b0;
    logic [63:0]  key = '0;
    logic [21:0]  frame = '0;
    logic [113:0] in_bus = '0;
    logic         busy1, done1, busy0, done0;
    logic [113:0] out1, out0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    a51_burst_decipher #(.DIRECTION(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .key(key), .frame(frame),
        .in(in_bus), .busy(busy1), .done(done1), .out(out1)
    );

    a51_burst_decipher #(.DIRECTION(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .key(key), .frame(frame),
        .in(in_bus), .busy(busy0), .done(done0), .out(out0)
    );

    // Registers as bit lists; taps and clocking positions listed by index.
    function automatic logic [113:0] ref_ks(input logic [63:0] k, input logic [21:0] f, input bit dir);
        bit           r[3][23];
        bit           en[3];
        int           len[3]    = '{19, 22, 23};
        int           cb[3]     = '{8, 10, 10};
        int           tap[3][4] = '{'{18, 17, 16, 13}, '{21, 20, -1, -1}, '{22, 21, 20, 7}};
        int           total;
        int           votes;
        bit           fb;
        bit           m;
        bit           lb;
        logic [113:0] ks;
        ks = '0;
        for (int j = 0; j < 3; j++)
            for (int b = 0; b < 23; b++) r[j][b] = 1'b0;
        total = 86 + 100 + (dir ? 114 : 0) + 114;
        for (int t = 0; t < total; t++) begin
            if (t < 86) begin
                for (int j = 0; j < 3; j++) en[j] = 1'b1;
            end else begin
                votes = int'(r[0][8]) + int'(r[1][10]) + int'(r[2][10]);
                m = (votes >= 2);
                for (int j = 0; j < 3; j++) en[j] = (r[j][cb[j]] == m);
            end
            for (int j = 0; j < 3; j++) begin
                if (en[j]) begin
                    fb = 1'b0;
                    for (int q = 0; q < 4; q++)
                        if (tap[j][q] >= 0) fb ^= r[j][tap[j][q]];
                    for (int b = len[j] - 1; b > 0; b--) r[j][b] = r[j][b-1];
                    r[j][0] = fb;
                end
            end
            if (t < 86) begin
                lb = (t < 64) ? k[t] : f[t-64];
                for (int j = 0; j < 3; j++) r[j][0] ^= lb;
            end
            if (t >= total - 114) ks[t - (total - 114)] = r[0][18] ^ r[1][21] ^ r[2][22];
        end
        return ks;
    endfunction

    task automatic chk(input string tag, input logic [113:0] obs, input logic [113:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [113:0] rand114();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[113:0];
    endfunction

    // Called just after a falling edge; returns #1 after the acceptance edge with inputs scrambled.
    task automatic kick(input bit d, input logic [63:0] k, input logic [21:0] f, input logic [113:0] x);
        logic [31:0] w;
        key = k; frame = f; in_bus = x;
        if (d) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clock);
        #1;
        start1 = 1'b0; start0 = 1'b0;
        w = $urandom;
        key = {$urandom, $urandom}; frame = w[21:0]; in_bus = rand114();
    endtask

    // Counts edges after acceptance until done is seen; optionally pulses start1 at a given count.
    task automatic wait_done(input bit d, input int pulse_at, output int lat, output logic [113:0] res);
        bit seen;
        seen = 1'b0;
        lat = 0;
        for (int g = 0; g < 1000 && !seen; g++) begin
            @(negedge clock);
            if (pulse_at >= 0) begin
                start1 = (lat == pulse_at);
                if (lat == pulse_at) begin key = ~key; in_bus = ~in_bus; end
            end
            if (d ? done1 : done0) seen = 1'b1;
            else begin
                @(posedge clock);
                lat++;
            end
        end
        start1 = 1'b0;
        res = d ? out1 : out0;
        if (seen) chk("busy_low_at_done", d ? busy1 : busy0, 0);
        else      chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [63:0]  k_lin;
        logic [21:0]  f_lin;
        logic [63:0]  k_r;
        logic [21:0]  f_r;
        logic [113:0] alt, ones, o_a, o_b, o_c, pt, ct;
        logic [31:0]  w;
        int           lat;

        k_lin = 64'h1223456789ABCDEF;
        f_lin = 22'h134;
        ones  = '1;
        alt   = {57{2'b10}};

        // Reset with start held high: reset must win.
        start1 = 1'b1; start0 = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", busy1, 0);
        chk("reset_done", done1, 0);
        chk("reset_out", out1, 0);
        chk("reset_busy_dir0", busy0, 0);
        start1 = 1'b0; start0 = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        // All-zero state gives zero keystream.
        kick(1, 64'h0, 22'h0, alt);
        chk("busy_after_accept", busy1, 1);
        wait_done(1, -1, lat, o_a);
        chk("zero_latency", lat, 414);
        chk("zero_out", o_a, alt);

        // Linearity and model match, DIRECTION=1.
        kick(1, k_lin, f_lin, '0);
        wait_done(1, -1, lat, o_a);
        chk("lin1_out0", o_a, ref_ks(k_lin, f_lin, 1'b1));
        kick(1, k_lin, f_lin, ones);
        wait_done(1, -1, lat, o_b);
        chk("lin1_xor", o_a ^ o_b, ones);

        // Linearity, model match and latency, DIRECTION=0.
        kick(0, k_lin, f_lin, '0);
        wait_done(0, -1, lat, o_c);
        chk("dir0_latency", lat, 300);
        chk("lin0_out0", o_c, ref_ks(k_lin, f_lin, 1'b0));
        chk("dir_split", (o_c !== o_a), 1);
        kick(0, k_lin, f_lin, ones);
        wait_done(0, -1, lat, o_b);
        chk("lin0_xor", o_c ^ o_b, ones);

        // Random round trips against the transmit-side model.
        for (int i = 0; i < 3; i++) begin
            k_r = {$urandom, $urandom};
            w   = $urandom;
            f_r = w[21:0];
            pt  = rand114();
            ct  = pt ^ ref_ks(k_r, f_r, 1'b1);
            kick(1, k_r, f_r, ct);
            wait_done(1, -1, lat, o_a);
            chk("roundtrip_dir1", o_a, pt);
            ct  = pt ^ ref_ks(k_r, f_r, 1'b0);
            kick(0, k_r, f_r, ct);
            wait_done(0, -1, lat, o_a);
            chk("roundtrip_dir0", o_a, pt);
        end

        // Start pulsed mid-run is ignored; start in done cycle is accepted.
        kick(1, k_lin, f_lin, '0);
        wait_done(1, 50, lat, o_a);
        chk("ignored_start_latency", lat, 414);
        chk("ignored_start_out", o_a, ref_ks(k_lin, f_lin, 1'b1));
        k_r = {$urandom, $urandom};
        kick(1, k_r, 22'h2A5, ones);
        chk("b2b_done_drops", done1, 0);
        chk("b2b_busy", busy1, 1);
        wait_done(1, -1, lat, o_a);
        chk("b2b_latency", lat, 414);
        chk("b2b_out", o_a, ones ^ ref_ks(k_r, 22'h2A5, 1'b1));

        // Reset during MIX aborts; next run is clean.
        kick(1, k_lin, f_lin, ones);
        repeat (120) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("midreset_busy", busy1, 0);
        chk("midreset_done", done1, 0);
        chk("midreset_out", out1, 0);
        reset_n = 1'b1;
        @(negedge clock);
        kick(1, k_lin, f_lin, alt);
        wait_done(1, -1, lat, o_a);
        chk("after_reset_latency", lat, 414);
        chk("after_reset_out", o_a, alt ^ ref_ks(k_lin, f_lin, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
